// File: rtl/breathing_pwm_mc.sv
// breathing_pwm_mc: multi-channel breathing PWM, sawtooth or triangle duty sweep.
// Ports: clk, rst, en, ch_en, mode -> pwm_out, cycle_done, sweep_done. Option macro: PHASE_STAGGER_EN.
module breathing_pwm_mc #(
  parameter int NUM_CH   = 4,
  parameter int DUTY_MIN = 1,
  parameter int DUTY_MAX = 16,
  parameter int LOW_MULT = 2,
  parameter int DUTY_W   = $clog2(DUTY_MAX + 1),
  parameter int CNT_W    = (LOW_MULT * DUTY_MAX > 1) ?
                           $clog2(LOW_MULT * DUTY_MAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              mode,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] cycle_done,
  output logic [NUM_CH-1:0] sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [DUTY_W-1:0] D_MIN = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] D_MAX = DUTY_W'(DUTY_MAX);
  localparam bit FLAT = (DUTY_MIN == DUTY_MAX);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef PHASE_STAGGER_EN
    localparam logic [DUTY_W-1:0] D_INIT =
      DUTY_W'(DUTY_MIN + (g % (DUTY_MAX - DUTY_MIN + 1)));
`else
    localparam logic [DUTY_W-1:0] D_INIT = D_MIN;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_nx;
    logic              up_q, up_d, up_nx;
    logic              cyc_q, cyc_d;
    logic              swp_q, swp_d;
    logic              hi_end, lo_end;

    assign hi_end = (int'(cnt_q) == int'(duty_q) - 1);
    assign lo_end = (int'(cnt_q) == LOW_MULT * int'(duty_q) - 1);

    // Duty step applied at the end of a LOW phase.
    always_comb begin
      duty_nx = duty_q;
      up_nx   = up_q;
      if (!mode) begin
        up_nx   = 1'b1;
        duty_nx = (duty_q == D_MAX) ? D_MIN : duty_q + 1'b1;
      end else if (!FLAT) begin
        if (duty_q == D_MAX) begin
          duty_nx = D_MAX - 1'b1;
          up_nx   = 1'b0;
        end else if (duty_q == D_MIN) begin
          duty_nx = D_MIN + 1'b1;
          up_nx   = 1'b1;
        end else if (up_q) begin
          duty_nx = duty_q + 1'b1;
        end else begin
          duty_nx = duty_q - 1'b1;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      up_d    = up_q;
      cyc_d   = 1'b0;
      swp_d   = 1'b0;
      if (!ch_en[g]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        duty_d  = D_INIT;
        up_d    = 1'b1;
      end else if (en) begin
        unique case (state_q)
          S_IDLE: begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end
          S_HIGH: begin
            if (hi_end) begin
              state_d = S_LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_LOW: begin
            if (lo_end) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              duty_d  = duty_nx;
              up_d    = up_nx;
              cyc_d   = 1'b1;
              swp_d   = (duty_nx == D_MIN);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        duty_q  <= D_INIT;
        up_q    <= 1'b1;
        cyc_q   <= 1'b0;
        swp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        duty_q  <= duty_d;
        up_q    <= up_d;
        cyc_q   <= cyc_d;
        swp_q   <= swp_d;
      end
    end

    assign pwm_out[g]    = (state_q == S_HIGH);
    assign cycle_done[g] = cyc_q;
    assign sweep_done[g] = swp_q;
  end

endmodule

// File: tb/tb_breathing_pwm_mc.sv
// tb_breathing_pwm_mc: random stimulus, scoreboard against a period-position model.
// Two DUTs: default parameters, and a flat-duty 2-channel build.
module tb_breathing_pwm_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] ch_en = '0;
  logic [3:0] pwm_a, cyc_a, swp_a;
  logic [1:0] pwm_b, cyc_b, swp_b;

  always #5 clk = ~clk;

  breathing_pwm_mc u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_en      (ch_en),
    .mode       (mode),
    .pwm_out    (pwm_a),
    .cycle_done (cyc_a),
    .sweep_done (swp_a)
  );

  breathing_pwm_mc #(
    .NUM_CH   (2),
    .DUTY_MIN (3),
    .DUTY_MAX (3),
    .LOW_MULT (1)
  ) u_flat (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_en      (ch_en[1:0]),
    .mode       (mode),
    .pwm_out    (pwm_b),
    .cycle_done (cyc_b),
    .sweep_done (swp_b)
  );

  typedef struct packed {
    logic [5:0] pwm;
    logic [5:0] cyc;
    logic [5:0] swp;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // Model: channels 0..3 are u_dut, 4..5 are u_flat.
  bit run[6];
  int t[6];
  int duty[6];
  bit up[6];

  function automatic int c_min(int c);
    return (c < 4) ? 1 : 3;
  endfunction

  function automatic int c_max(int c);
    return (c < 4) ? 16 : 3;
  endfunction

  function automatic int c_lm(int c);
    return (c < 4) ? 2 : 1;
  endfunction

  function automatic int init_duty(int c);
    int idx;
    idx = (c < 4) ? c : c - 4;
`ifdef PHASE_STAGGER_EN
    return c_min(c) + idx % (c_max(c) - c_min(c) + 1);
`else
    return c_min(c) + 0 * idx;
`endif
  endfunction

  task automatic next_duty(input int c, input logic m);
    int mn, mx;
    mn = c_min(c);
    mx = c_max(c);
    if (!m) begin
      up[c]   = 1'b1;
      duty[c] = (duty[c] >= mx) ? mn : duty[c] + 1;
    end else if (mn != mx) begin
      if (duty[c] == mx) up[c] = 1'b0;
      else if (duty[c] == mn) up[c] = 1'b1;
      duty[c] = up[c] ? duty[c] + 1 : duty[c] - 1;
    end
  endtask

  task automatic model_step(input logic r, input logic e,
                            input logic [5:0] ce, input logic m,
                            output exp_t x);
    x = '0;
    for (int c = 0; c < 6; c++) begin
      if (r || !ce[c]) begin
        run[c]  = 1'b0;
        t[c]    = 0;
        duty[c] = init_duty(c);
        up[c]   = 1'b1;
      end else if (e) begin
        if (!run[c]) begin
          run[c] = 1'b1;
          t[c]   = 0;
        end else begin
          t[c]++;
          if (t[c] == (1 + c_lm(c)) * duty[c]) begin
            t[c] = 0;
            next_duty(c, m);
            x.cyc[c] = 1'b1;
            x.swp[c] = (duty[c] == c_min(c));
          end
        end
      end
      x.pwm[c] = run[c] && (t[c] < duty[c]);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [3:0] ce, input logic m);
    exp_t x;
    logic [17:0] now;
    @(negedge clk);
    #2;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      now = {pwm_b, pwm_a, cyc_b, cyc_a, swp_b, swp_a};
      vecs++;
      if (now != '0) begin
        errs++;
        $display("FAIL async_rst t=%0t got=%h need=0", $time, now);
      end
    end
    rst   = r;
    en    = e;
    ch_en = ce;
    mode  = m;
    model_step(r, e, {ce[1:0], ce}, m, x);
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        a.pwm = {pwm_b, pwm_a};
        a.cyc = {cyc_b, cyc_a};
        a.swp = {swp_b, swp_a};
        vecs++;
        if (a != x) begin
          errs++;
          $display("FAIL outputs t=%0t got pwm=%b cyc=%b swp=%b need pwm=%b cyc=%b swp=%b",
                   $time, a.pwm, a.cyc, a.swp, x.pwm, x.cyc, x.swp);
        end
      end
    end
  end

  task automatic rand_run(input int n);
    logic [3:0] ce;
    logic       m;
    ce = ch_en;
    m  = mode;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 63) == 0) ce[b] = ~ce[b];
      if ($urandom_range(0, 299) == 0) m = ~m;
      step(1'b0, $urandom_range(0, 7) != 0, ce, m);
    end
  endtask

  initial begin : stim
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 900; k++) step(1'b0, 1'b1, 4'b0001, 1'b0);
    for (int k = 0; k < 1600; k++) step(1'b0, 1'b1, 4'b0001, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 4'b0000, 1'b0);
    rand_run(3000);
    for (int k = 0; k < 237; k++) step(1'b0, 1'b1, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 1'b0);
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 4'b1111, 1'b1);
    rand_run(2000);
    @(posedge clk);
    #3;
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d need=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
